// File: rtl/riscv_ctrl_pkg.sv
// Shared opcode, ALU-code and FSM-state definitions for the multicycle control slice.
// Pure constants and decode helpers; no state, no latency, no flow control.
package riscv_ctrl_pkg;

   localparam logic [6:0] OP_R  = 7'b0110011;
   localparam logic [6:0] OP_I  = 7'b0010011;
   localparam logic [6:0] OP_LW = 7'b0000011;
   localparam logic [6:0] OP_S  = 7'b0100011;
   localparam logic [6:0] OP_B  = 7'b1100011;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_SRL = 4'b1000;
   localparam logic [3:0] ALU_SLL = 4'b1001;
   localparam logic [3:0] ALU_SRA = 4'b1010;
   localparam logic [3:0] ALU_XOR = 4'b1101;

   typedef enum logic [2:0] {
      ST_IF   = 3'd0,
      ST_ID   = 3'd1,
      ST_EX   = 3'd2,
      ST_MEM  = 3'd3,
      ST_WB   = 3'd4,
      ST_HALT = 3'd5
   } state_e;

   function automatic logic is_legal(input logic [6:0] op);
      return (op == OP_R) || (op == OP_I) || (op == OP_LW) || (op == OP_S) || (op == OP_B);
   endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational opcode/funct3/instr[30] to ALU operation code.
// Zero latency, no flow control; unknown encodings fall back to ADD.
module alu_decoder
   import riscv_ctrl_pkg::*;
(
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       bit30,
   output logic [3:0] alu_ctrl
);

   always_comb begin
      alu_ctrl = ALU_ADD;
      case (opcode)
         OP_B: alu_ctrl = ALU_SUB;
         OP_R, OP_I: begin
            case (funct3)
               // instr[30] is part of the immediate for ADDI, so only R-type may select SUB
               3'b000:  alu_ctrl = ((opcode == OP_R) && bit30) ? ALU_SUB : ALU_ADD;
               3'b001:  alu_ctrl = ALU_SLL;
               3'b010:  alu_ctrl = ALU_SLT;
               3'b100:  alu_ctrl = ALU_XOR;
               3'b101:  alu_ctrl = bit30 ? ALU_SRA : ALU_SRL;
               3'b110:  alu_ctrl = ALU_OR;
               3'b111:  alu_ctrl = ALU_AND;
               default: alu_ctrl = ALU_ADD;
            endcase
         end
         default: alu_ctrl = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle IF/ID/EX/MEM/WB sequencer with retired-instruction counter; 2-5 cycles per instruction.
// Strobes are combinational from state+instr; ILLEGAL_TRAP_EN parks illegal opcodes in a HALT state.
module multicycle_control
   import riscv_ctrl_pkg::*;
#(
   parameter int INSTRET_W = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [31:0]          instr,
   input  logic                 Zero,
   output logic                 ALUSrc,
   output logic                 MemToReg,
   output logic                 RegWrite,
   output logic                 MemRead,
   output logic                 MemWrite,
   output logic [3:0]           ALUCtrl,
   output logic                 loadPC,
   output logic                 PCSrc,
   output logic                 illegal,
   output logic [INSTRET_W-1:0] instret
);

   state_e                 state_q, state_d;
   logic [INSTRET_W-1:0]   instret_q, instret_d;
   logic [6:0]             opcode;
   logic [3:0]             dec_alu;
   logic                   legal;
   logic                   unused_instr_bits;

   assign opcode            = instr[6:0];
   assign legal             = is_legal(opcode);
   assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

   alu_decoder u_alu_decoder (
      .opcode   (opcode),
      .funct3   (instr[14:12]),
      .bit30    (instr[30]),
      .alu_ctrl (dec_alu)
   );

   always_comb begin
      state_d = ST_IF;
      case (state_q)
         ST_IF: state_d = ST_ID;
         ST_ID: begin
            if (legal) state_d = ST_EX;
`ifdef ILLEGAL_TRAP_EN
            else       state_d = ST_HALT;
`else
            else       state_d = ST_IF;
`endif
         end
         ST_EX: begin
            if (opcode == OP_LW || opcode == OP_S) state_d = ST_MEM;
            else if (opcode == OP_B)               state_d = ST_IF;
            else                                   state_d = ST_WB;
         end
         ST_MEM:  state_d = (opcode == OP_LW) ? ST_WB : ST_IF;
         ST_WB:   state_d = ST_IF;
`ifdef ILLEGAL_TRAP_EN
         ST_HALT: state_d = ST_HALT;
`endif
         default: state_d = ST_IF;
      endcase
   end

   always_comb begin
      ALUSrc   = 1'b0;
      MemToReg = 1'b0;
      RegWrite = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      loadPC   = 1'b0;
      PCSrc    = 1'b0;
      ALUCtrl  = ALU_ADD;
      case (state_q)
         ST_ID: begin
`ifndef ILLEGAL_TRAP_EN
            // Illegal opcodes retire as a NOP: step past them to PC+4
            loadPC = !legal;
`endif
         end
         ST_EX: begin
            ALUCtrl = dec_alu;
            ALUSrc  = (opcode == OP_I) || (opcode == OP_LW) || (opcode == OP_S);
            if (opcode == OP_B) begin
               loadPC = 1'b1;
               PCSrc  = Zero;
            end
         end
         ST_MEM: begin
            ALUCtrl = dec_alu;
            ALUSrc  = 1'b1;
            if (opcode == OP_LW) begin
               MemRead = 1'b1;
            end else begin
               MemWrite = 1'b1;
               loadPC   = 1'b1;
            end
         end
         ST_WB: begin
            ALUCtrl  = dec_alu;
            ALUSrc   = (opcode != OP_R);
            MemToReg = (opcode == OP_LW);
            RegWrite = 1'b1;
            loadPC   = 1'b1;
         end
         default: ;
      endcase
   end

   assign instret_d = loadPC ? instret_q + {{(INSTRET_W-1){1'b0}}, 1'b1} : instret_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IF;
         instret_q <= '0;
      end else begin
         state_q   <= state_d;
         instret_q <= instret_d;
      end
   end

   assign instret = instret_q;
`ifdef ILLEGAL_TRAP_EN
   assign illegal = (state_q == ST_HALT);
`else
   assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle strobe vectors for each instruction class.
// Honours ILLEGAL_TRAP_EN in the illegal-opcode scenario.
module tb_multicycle_control;

   logic        clk;
   logic        rst;
   logic [31:0] instr;
   logic        Zero;
   logic        ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, loadPC, PCSrc, illegal;
   logic [3:0]  ALUCtrl;
   logic [31:0] instret;
   logic [10:0] obs;

   int passed = 0;
   int total  = 0;

   // {ALUSrc,MemToReg,RegWrite,MemRead,MemWrite,loadPC,PCSrc,ALUCtrl}
   localparam logic [10:0] IDLE    = 11'b0000000_0010;
   localparam logic [10:0] R_WB    = 11'b0010010_0010;
   localparam logic [10:0] LW_EX   = 11'b1000000_0010;
   localparam logic [10:0] LW_MEM  = 11'b1001000_0010;
   localparam logic [10:0] LW_WB   = 11'b1110010_0010;
   localparam logic [10:0] SW_MEM  = 11'b1000110_0010;
   localparam logic [10:0] SRA_EX  = 11'b1000000_1010;
   localparam logic [10:0] SRA_WB  = 11'b1010010_1010;
   localparam logic [10:0] ADDI_EX = 11'b1000000_0010;
   localparam logic [10:0] ADDI_WB = 11'b1010010_0010;
   localparam logic [10:0] B_EX_T  = 11'b0000011_0110;
   localparam logic [10:0] B_EX_N  = 11'b0000010_0110;
   localparam logic [10:0] SUB_EX  = 11'b0000000_0110;
   localparam logic [10:0] ILL_ID  = 11'b0000010_0010;

   assign obs = {ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, loadPC, PCSrc, ALUCtrl};

   multicycle_control #(.INSTRET_W(32)) dut (
      .clk      (clk),
      .rst      (rst),
      .instr    (instr),
      .Zero     (Zero),
      .ALUSrc   (ALUSrc),
      .MemToReg (MemToReg),
      .RegWrite (RegWrite),
      .MemRead  (MemRead),
      .MemWrite (MemWrite),
      .ALUCtrl  (ALUCtrl),
      .loadPC   (loadPC),
      .PCSrc    (PCSrc),
      .illegal  (illegal),
      .instret  (instret)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      rst   = 1'b0;
      instr = 32'h002081B3;
      Zero  = 1'bx;
      repeat (2) @(negedge clk);
      #1;
      total++;
      if (obs !== IDLE) $display("FAIL reset_strobes: got %b expected %b", obs, IDLE); else passed++;
      total++;
      if (instret !== 32'd0) $display("FAIL reset_instret: got %0d expected 0", instret); else passed++;
      total++;
      if (illegal !== 1'b0) $display("FAIL reset_illegal: got %b expected 0", illegal); else passed++;
      rst = 1'b1;
   endtask

   task automatic test_r_type();
      logic [10:0] e [4] = '{IDLE, IDLE, IDLE, R_WB};
      instr = 32'h002081B3;
      for (int c = 0; c < 4; c++) begin
         if (c > 0) @(negedge clk);
         #1;
         total++;
         if (obs !== e[c]) $display("FAIL add_cycle%0d: got %b expected %b", c, obs, e[c]); else passed++;
      end
      @(negedge clk); #1;
      total++;
      if (instret !== 32'd1 || obs !== IDLE) $display("FAIL add_retire: instret=%0d strobes=%b expected 1 %b", instret, obs, IDLE); else passed++;
   endtask

   task automatic test_load();
      logic [10:0] e [5] = '{IDLE, IDLE, LW_EX, LW_MEM, LW_WB};
      instr = 32'h00802283;
      for (int c = 0; c < 5; c++) begin
         if (c > 0) @(negedge clk);
         #1;
         total++;
         if (obs !== e[c]) $display("FAIL lw_cycle%0d: got %b expected %b", c, obs, e[c]); else passed++;
      end
      @(negedge clk); #1;
      total++;
      if (instret !== 32'd2 || obs !== IDLE) $display("FAIL lw_retire: instret=%0d strobes=%b expected 2 %b", instret, obs, IDLE); else passed++;
   endtask

   task automatic test_store();
      logic [10:0] e [4] = '{IDLE, IDLE, LW_EX, SW_MEM};
      instr = 32'h00502623;
      for (int c = 0; c < 4; c++) begin
         if (c > 0) @(negedge clk);
         #1;
         total++;
         if (obs !== e[c]) $display("FAIL sw_cycle%0d: got %b expected %b", c, obs, e[c]); else passed++;
      end
      @(negedge clk); #1;
      total++;
      if (instret !== 32'd3 || obs !== IDLE) $display("FAIL sw_retire: instret=%0d strobes=%b expected 3 %b", instret, obs, IDLE); else passed++;
   endtask

   task automatic test_i_type();
      logic [10:0] e_sra  [4] = '{IDLE, IDLE, SRA_EX, SRA_WB};
      logic [10:0] e_addi [4] = '{IDLE, IDLE, ADDI_EX, ADDI_WB};
      instr = 32'h4030D093;
      for (int c = 0; c < 4; c++) begin
         if (c > 0) @(negedge clk);
         #1;
         total++;
         if (obs !== e_sra[c]) $display("FAIL srai_cycle%0d: got %b expected %b", c, obs, e_sra[c]); else passed++;
      end
      @(negedge clk);
      instr = 32'hC0000093;
      for (int c = 0; c < 4; c++) begin
         if (c > 0) @(negedge clk);
         #1;
         total++;
         if (obs !== e_addi[c]) $display("FAIL addi_cycle%0d: got %b expected %b", c, obs, e_addi[c]); else passed++;
      end
      @(negedge clk); #1;
      total++;
      if (instret !== 32'd5) $display("FAIL itype_retire: instret=%0d expected 5", instret); else passed++;
   endtask

   task automatic test_branch();
      logic [10:0] e_t [3] = '{IDLE, IDLE, B_EX_T};
      logic [10:0] e_n [3] = '{IDLE, IDLE, B_EX_N};
      instr = 32'h00208463;
      for (int c = 0; c < 3; c++) begin
         if (c > 0) @(negedge clk);
         Zero = (c == 2) ? 1'b1 : 1'bx;
         #1;
         total++;
         if (obs !== e_t[c]) $display("FAIL beq_taken_cycle%0d: got %b expected %b", c, obs, e_t[c]); else passed++;
      end
      @(negedge clk);
      Zero = 1'bx;
      for (int c = 0; c < 3; c++) begin
         if (c > 0) @(negedge clk);
         Zero = (c == 2) ? 1'b0 : 1'bx;
         #1;
         total++;
         if (obs !== e_n[c]) $display("FAIL beq_not_taken_cycle%0d: got %b expected %b", c, obs, e_n[c]); else passed++;
      end
      @(negedge clk);
      Zero = 1'bx;
      #1;
      total++;
      if (instret !== 32'd7 || obs !== IDLE) $display("FAIL beq_retire: instret=%0d strobes=%b expected 7 %b", instret, obs, IDLE); else passed++;
   endtask

   task automatic test_sub_abort();
      logic [10:0] e [3] = '{IDLE, IDLE, SUB_EX};
      instr = 32'h402081B3;
      for (int c = 0; c < 3; c++) begin
         if (c > 0) @(negedge clk);
         #1;
         total++;
         if (obs !== e[c]) $display("FAIL sub_cycle%0d: got %b expected %b", c, obs, e[c]); else passed++;
      end
      total++;
      if (instret !== 32'd7) $display("FAIL sub_pre_abort_instret: got %0d expected 7", instret); else passed++;
      rst = 1'b0;
      #1;
      total++;
      if (obs !== IDLE) $display("FAIL abort_strobes: got %b expected %b", obs, IDLE); else passed++;
      total++;
      if (instret !== 32'd0) $display("FAIL abort_instret: got %0d expected 0", instret); else passed++;
      @(negedge clk);
      rst = 1'b1;
      #1;
   endtask

   task automatic test_illegal();
      instr = 32'h0000007F;
      #1;
      total++;
      if (obs !== IDLE) $display("FAIL illegal_if: got %b expected %b", obs, IDLE); else passed++;
      @(negedge clk); #1;
`ifdef ILLEGAL_TRAP_EN
      total++;
      if (obs !== IDLE || illegal !== 1'b0) $display("FAIL illegal_id: strobes=%b illegal=%b expected %b 0", obs, illegal, IDLE); else passed++;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk); #1;
         total++;
         if (obs !== IDLE || illegal !== 1'b1 || instret !== 32'd0)
            $display("FAIL halt_cycle%0d: strobes=%b illegal=%b instret=%0d expected %b 1 0", c, obs, illegal, instret, IDLE);
         else passed++;
      end
      rst = 1'b0;
      #1;
      total++;
      if (illegal !== 1'b0) $display("FAIL halt_clear: illegal=%b expected 0", illegal); else passed++;
      @(negedge clk);
      rst = 1'b1;
`else
      total++;
      if (obs !== ILL_ID || illegal !== 1'b0) $display("FAIL illegal_id: strobes=%b illegal=%b expected %b 0", obs, illegal, ILL_ID); else passed++;
      @(negedge clk); #1;
      total++;
      if (instret !== 32'd1 || obs !== IDLE || illegal !== 1'b0)
         $display("FAIL illegal_retire: instret=%0d strobes=%b illegal=%b expected 1 %b 0", instret, obs, illegal, IDLE);
      else passed++;
`endif
   endtask

   initial begin
      test_reset();
      test_r_type();
      test_load();
      test_store();
      test_i_type();
      test_branch();
      test_sub_abort();
      test_illegal();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
